// File: rtl/trivium_ctrl.sv
// Sequencing controller for a three-register Trivium core: key/IV load,
// fixed-length warm-up, then keystream bit packing into 32-bit words.
module trivium_ctrl #(
    parameter int WARMUP_CYC = 1152,
    parameter int CNT_W      = 11
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        start_i,
    input  logic        cfg_vld_i,
    output logic        cfg_rdy_o,
    input  logic [31:0] cfg_dat_i,
    output logic [2:0]  ld_a_o,
    output logic [2:0]  ld_b_o,
    output logic [31:0] ld_dat_o,
    output logic        ce_o,
    input  logic        z_i,
    output logic [31:0] ks_dat_o,
    output logic        ks_vld_o,
    input  logic        ks_rdy_i,
    output logic        run_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_STREAM
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(WARMUP_CYC - 1);

    state_t           r_state;
    logic [2:0]       r_widx;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bcnt;
    logic [30:0]      r_coll;
    logic [31:0]      r_ks_dat;
    logic             r_ks_vld;
    logic             r_cfg_rdy;
    logic             r_run;

    logic             w_acc;
    logic             w_stall;
    logic             w_ce;
    logic             w_word;
    logic [2:0]       w_ld_a;
    logic [2:0]       w_ld_b;

    assign w_acc   = cfg_vld_i && r_cfg_rdy;
    // Stall only when the last collector slot would need the still-occupied output register.
    assign w_stall = (r_bcnt == 5'd31) && r_ks_vld && !ks_rdy_i;
    assign w_word  = (r_state == S_STREAM) && w_ce && (r_bcnt == 5'd31);

    always_comb begin
        w_ce = 1'b0;
        case (r_state)
            S_INIT:   w_ce = 1'b1;
            S_STREAM: w_ce = !w_stall;
            default:  w_ce = 1'b0;
        endcase
    end

    always_comb begin
        w_ld_a = 3'b000;
        w_ld_b = 3'b000;
        if (w_acc) begin
            case (r_widx)
                3'd0:    w_ld_a = 3'b001;
                3'd1:    w_ld_a = 3'b010;
                3'd2:    w_ld_a = 3'b100;
                3'd3:    w_ld_b = 3'b001;
                3'd4:    w_ld_b = 3'b010;
                3'd5:    w_ld_b = 3'b100;
                default: w_ld_a = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state   <= S_IDLE;
            r_widx    <= '0;
            r_cnt     <= '0;
            r_bcnt    <= '0;
            r_coll    <= '0;
            r_ks_dat  <= '0;
            r_ks_vld  <= 1'b0;
            r_cfg_rdy <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state   <= S_LOAD;
                        r_widx    <= '0;
                        r_cfg_rdy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_acc) begin
                        if (r_widx == 3'd5) begin
                            r_state   <= S_INIT;
                            r_cnt     <= '0;
                            r_cfg_rdy <= 1'b0;
                        end else begin
                            r_widx <= r_widx + 3'd1;
                        end
                    end
                end
                S_INIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state <= S_STREAM;
                        r_run   <= 1'b1;
                        r_bcnt  <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_ce) begin
                        r_bcnt <= r_bcnt + 5'd1;
                        if (r_bcnt != 5'd31) begin
                            r_coll[r_bcnt] <= z_i;
                        end
                    end
                    if (w_word) begin
                        r_ks_dat <= {z_i, r_coll};
                        r_ks_vld <= 1'b1;
                    end else if (r_ks_vld && ks_rdy_i) begin
                        r_ks_vld <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_rdy_o = r_cfg_rdy;
    assign ld_a_o    = w_ld_a;
    assign ld_b_o    = w_ld_b;
    assign ld_dat_o  = cfg_dat_i;
    assign ce_o      = w_ce;
    assign ks_dat_o  = r_ks_dat;
    assign ks_vld_o  = r_ks_vld;
    assign run_o     = r_run;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Bench for trivium_ctrl: keystream words are predicted from the bits fed on
// z_i during shift cycles and checked against every output transfer.
module tb_trivium_ctrl;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        start = 1'b0;
    logic        cfg_vld = 1'b0;
    logic [31:0] cfg_dat = '0;
    logic        z = 1'b0;
    logic        ks_rdy = 1'b0;

    logic        cfg_rdy, ce, ks_vld, run;
    logic [2:0]  ld_a, ld_b;
    logic [31:0] ld_dat, ks_dat;

    logic        cfg_rdy5, ce5, ks_vld5, run5;
    logic [2:0]  ld_a5, ld_b5;
    logic [31:0] ld_dat5, ks_dat5;

    always #5 clk = ~clk;

    trivium_ctrl #(.WARMUP_CYC(1152), .CNT_W(11)) dut (
        .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .cfg_vld_i(cfg_vld),
        .cfg_rdy_o(cfg_rdy), .cfg_dat_i(cfg_dat), .ld_a_o(ld_a), .ld_b_o(ld_b),
        .ld_dat_o(ld_dat), .ce_o(ce), .z_i(z), .ks_dat_o(ks_dat),
        .ks_vld_o(ks_vld), .ks_rdy_i(ks_rdy), .run_o(run)
    );

    trivium_ctrl #(.WARMUP_CYC(5), .CNT_W(3)) dut5 (
        .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .cfg_vld_i(cfg_vld),
        .cfg_rdy_o(cfg_rdy5), .cfg_dat_i(cfg_dat), .ld_a_o(ld_a5), .ld_b_o(ld_b5),
        .ld_dat_o(ld_dat5), .ce_o(ce5), .z_i(z), .ks_dat_o(ks_dat5),
        .ks_vld_o(ks_vld5), .ks_rdy_i(ks_rdy), .run_o(run5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sb_q[$];
    logic [31:0] m_word = '0;
    int          nbits = 0;
    int          zmode = 0;

    logic        s_rdy, s_ce, s_vld, s_run;
    logic [2:0]  s_ld_a, s_ld_b;
    logic [31:0] s_ld_dat, s_dat;
    int          ce_init = 0, ce5_init = 0, lat = 0, first_lat = -1;

    // One clock cycle: drive z_i, sample mid-cycle, run scoreboard, advance past the edge.
    task automatic cyc();
        logic [31:0] exp_w;
        @(negedge clk);
        z = (zmode == 1) ? 1'b1 : ((nbits % 2) == 0);
        #1;
        s_rdy = cfg_rdy; s_ce = ce; s_vld = ks_vld; s_run = run;
        s_ld_a = ld_a; s_ld_b = ld_b; s_ld_dat = ld_dat; s_dat = ks_dat;
        lat++;
        if (s_ce && !s_run) ce_init++;
        if (ce5 && !run5) ce5_init++;
        if (s_vld && first_lat < 0) first_lat = lat;
        if (s_run && s_ce) begin
            m_word[nbits % 32] = z;
            nbits++;
            if ((nbits % 32) == 0) sb_q.push_back(m_word);
        end
        if (s_vld && ks_rdy) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_word: got %08h, required no word", s_dat);
            end else begin
                exp_w = sb_q.pop_front();
                if (s_dat !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_word: got %08h, required %08h", s_dat, exp_w);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb_q.delete();
        nbits = 0;
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        start = 1'b1;
        #1;
        n_tests++;
        if ({cfg_rdy, ld_a, ld_b, ce, ks_vld, run, ks_dat} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b lda=%b ldb=%b ce=%b vld=%b run=%b dat=%08h, required all 0",
                     cfg_rdy, ld_a, ld_b, ce, ks_vld, run, ks_dat);
        end
        cyc(); cyc();
        n_tests++;
        if (s_rdy !== 1'b0 || s_run !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_start: got rdy=%b run=%b, required 0 0", s_rdy, s_run);
        end
        start = 1'b0;
        n_rst = 1'b1;
        clear_model();
        cyc();
    endtask

    task automatic test_load(input bit bubble);
        logic [31:0] w;
        logic [2:0]  ea, eb;
        cfg_vld = 1'b1; cfg_dat = 32'hA5A5A5A5; start = 1'b0;
        cyc();
        n_tests++;
        if (s_ld_a !== 3'b000 || s_ld_b !== 3'b000 || s_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle_ignore: got lda=%b ldb=%b rdy=%b, required 000 000 0", s_ld_a, s_ld_b, s_rdy);
        end
        cfg_vld = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bubble && i == 2) begin
                cfg_vld = 1'b0; cfg_dat = 32'hDEADBEEF;
                cyc();
                n_tests++;
                if (s_ld_a !== 3'b000 || s_ld_b !== 3'b000 || s_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_bubble: got lda=%b ldb=%b rdy=%b, required 000 000 1", s_ld_a, s_ld_b, s_rdy);
                end
            end
            w = 32'(32'h11111111 * (i + 1));
            ea = (i < 3) ? (3'b001 << i) : 3'b000;
            eb = (i >= 3) ? (3'b001 << (i - 3)) : 3'b000;
            cfg_vld = 1'b1; cfg_dat = w;
            cyc();
            n_tests++;
            if (s_ld_a !== ea || s_ld_b !== eb || s_ld_dat !== w || s_ce !== 1'b0 || s_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_word%0d: got lda=%b ldb=%b dat=%08h ce=%b rdy=%b, required %b %b %08h 0 1",
                         i, s_ld_a, s_ld_b, s_ld_dat, s_ce, s_rdy, ea, eb, w);
            end
        end
        cfg_vld = 1'b0;
        ce_init = 0; ce5_init = 0; lat = 0; first_lat = -1;
    endtask

    task automatic test_warmup(input bit chk5);
        int guard = 0;
        int rdy_seen = 0;
        while (!s_run && guard < 3000) begin
            cyc();
            if (s_rdy) rdy_seen++;
            guard++;
        end
        n_tests++;
        if (!s_run || ce_init != 1152) begin
            n_fail++;
            $display("FAIL warmup_count: got run=%b ce_cycles=%0d, required 1 1152", s_run, ce_init);
        end
        n_tests++;
        if (rdy_seen != 0) begin
            n_fail++;
            $display("FAIL warmup_no_restart: got cfg_rdy cycles=%0d, required 0", rdy_seen);
        end
        if (chk5) begin
            n_tests++;
            if (ce5_init != 5) begin
                n_fail++;
                $display("FAIL warmup_count_w5: got %0d, required 5", ce5_init);
            end
        end
    endtask

    task automatic test_packing();
        int guard = 0;
        while (first_lat < 0 && guard < 100) begin
            cyc();
            guard++;
        end
        n_tests++;
        if (first_lat != 1185) begin
            n_fail++;
            $display("FAIL first_latency: got %0d, required 1185", first_lat);
        end
        n_tests++;
        if (s_vld !== 1'b1 || s_dat !== 32'h55555555) begin
            n_fail++;
            $display("FAIL packing_order: got vld=%b dat=%08h, required 1 55555555", s_vld, s_dat);
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0, bad_gap = 0, drops = 0, last = 0;
        for (int c = 1; c <= 128; c++) begin
            cyc();
            if (!s_ce) drops++;
            if (s_vld) begin
                nv++;
                if (c - last != 32) bad_gap++;
                last = c;
            end
        end
        n_tests++;
        if (nv != 4 || bad_gap != 0) begin
            n_fail++;
            $display("FAIL b2b_rate: got words=%0d bad_gaps=%0d, required 4 0", nv, bad_gap);
        end
        n_tests++;
        if (drops != 0) begin
            n_fail++;
            $display("FAIL b2b_ce: got ce low cycles=%0d, required 0", drops);
        end
    endtask

    task automatic test_reset_mid_init();
        n_rst = 1'b0;
        cyc();
        n_rst = 1'b1;
        clear_model();
        test_load(1'b0);
        for (int i = 0; i < 600; i++) cyc();
        n_tests++;
        if (s_ce !== 1'b1 || s_run !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_init_state: got ce=%b run=%b, required 1 0", s_ce, s_run);
        end
        n_rst = 1'b0;
        #1;
        n_tests++;
        if ({cfg_rdy, ld_a, ld_b, ce, ks_vld, run, ks_dat} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got rdy=%b lda=%b ldb=%b ce=%b vld=%b run=%b dat=%08h, required all 0",
                     cfg_rdy, ld_a, ld_b, ce, ks_vld, run, ks_dat);
        end
        cyc();
        n_tests++;
        if (s_ce !== 1'b0 || s_rdy !== 1'b0 || s_vld !== 1'b0 || s_run !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: got ce=%b rdy=%b vld=%b run=%b, required 0 0 0 0", s_ce, s_rdy, s_vld, s_run);
        end
        n_rst = 1'b1;
        clear_model();
        cyc();
    endtask

    task automatic test_backpressure();
        int guard = 0;
        int bad = 0;
        zmode = 1; ks_rdy = 1'b0;
        test_load(1'b1);
        start = 1'b1;
        test_warmup(1'b0);
        while (s_ce && guard < 200) begin
            cyc();
            guard++;
        end
        n_tests++;
        if (s_ce !== 1'b0 || nbits != 63) begin
            n_fail++;
            $display("FAIL bp_stall_point: got ce=%b bits=%0d, required 0 63", s_ce, nbits);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (s_ce !== 1'b0 || s_vld !== 1'b1 || s_dat !== 32'hFFFFFFFF) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles, required 0", bad);
        end
        n_tests++;
        if (s_run !== 1'b1 || s_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_start_ignored: got run=%b rdy=%b, required 1 0", s_run, s_rdy);
        end
        ks_rdy = 1'b1;
        cyc();
        n_tests++;
        if (s_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume: got ce=%b, required 1", s_ce);
        end
        ks_rdy = 1'b0;
        cyc();
        n_tests++;
        if (s_vld !== 1'b1 || s_dat !== 32'hFFFFFFFF || nbits != 65 || sb_q.size() != 1) begin
            n_fail++;
            $display("FAIL bp_second_word: got vld=%b dat=%08h bits=%0d pending=%0d, required 1 ffffffff 65 1",
                     s_vld, s_dat, nbits, sb_q.size());
        end
        start = 1'b0;
        ks_rdy = 1'b1;
        for (int i = 0; i < 100; i++) cyc();
        n_tests++;
        if (sb_q.size() > 1) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d words pending, required at most 1", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        zmode = 0; ks_rdy = 1'b1;
        test_load(1'b1);
        test_warmup(1'b1);
        test_packing();
        test_back_to_back();
        test_reset_mid_init();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
